// File: rtl/switch_debounce_fsm_pkg.sv
// Shared definitions for the switch debouncer: state encoding and a
// constant-evaluable ceil(log2) helper for sizing counters.
package switch_debounce_fsm_pkg;

    typedef enum logic [1:0] {
        ZERO  = 2'b00,
        WAIT1 = 2'b01,
        ONE   = 2'b10,
        WAIT0 = 2'b11
    } state_t;

    // Returns the number of bits needed to index 'value' distinct items.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/switch_debounce_fsm_sync_2ff.sv
// Generic 1-bit two-flop synchronizer for bringing an asynchronous input
// into the clk domain; clears to 0 on an active-low asynchronous reset.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/switch_debounce_fsm.sv
// Switch debouncer: synchronizes a raw switch and only accepts a level change
// after STABLE consecutive stable sample periods of 2^CNT_W cycles each.
module switch_debounce_fsm
    import switch_debounce_fsm_pkg::*;
#(
    parameter int CNT_W  = 19,
    parameter int STABLE = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic sw,
    output logic db_level,
    output logic busy
);

    localparam int STB_W = clog2(STABLE + 1);
    localparam logic [CNT_W-1:0] Q_LAST   = '1;
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE - 1);

    logic             sw_sync;
    state_t           state;
    logic [CNT_W-1:0] q;
    logic [STB_W-1:0] stb;
    logic             sample_tick;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (sw),
        .q     (sw_sync)
    );

    assign sample_tick = (q == Q_LAST) && ((state == WAIT1) || (state == WAIT0));

    // Outputs are registered together with the state so they are pure Moore
    // decodes with no path from sw.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ZERO;
            q        <= '0;
            stb      <= '0;
            db_level <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                ZERO: begin
                    if (sw_sync) begin
                        state <= WAIT1;
                        q     <= '0;
                        stb   <= '0;
                        busy  <= 1'b1;
                    end
                end
                WAIT1: begin
                    q <= q + CNT_W'(1);
                    // A reversal wins over a coincident sample tick.
                    if (!sw_sync) begin
                        state <= ZERO;
                        q     <= '0;
                        busy  <= 1'b0;
                    end else if (sample_tick) begin
                        if (stb == STB_LAST) begin
                            state    <= ONE;
                            q        <= '0;
                            db_level <= 1'b1;
                            busy     <= 1'b0;
                        end else begin
                            stb <= stb + STB_W'(1);
                        end
                    end
                end
                ONE: begin
                    if (!sw_sync) begin
                        state <= WAIT0;
                        q     <= '0;
                        stb   <= '0;
                        busy  <= 1'b1;
                    end
                end
                WAIT0: begin
                    q <= q + CNT_W'(1);
                    if (sw_sync) begin
                        state <= ONE;
                        q     <= '0;
                        busy  <= 1'b0;
                    end else if (sample_tick) begin
                        if (stb == STB_LAST) begin
                            state    <= ZERO;
                            q        <= '0;
                            db_level <= 1'b0;
                            busy     <= 1'b0;
                        end else begin
                            stb <= stb + STB_W'(1);
                        end
                    end
                end
                default: begin
                    state    <= ZERO;
                    q        <= '0;
                    db_level <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
